// File: rtl/id_hazard_forward_unit_pkg.sv
// Shared types and encodings for the ID-stage hazard detection / forwarding unit.
package id_hazard_forward_unit_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FWD_SEL_W  = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [FWD_SEL_W-1:0]  fwd_sel_t;

    localparam fwd_sel_t FWD_REG      = 2'd0;
    localparam fwd_sel_t FWD_EXE_ALU  = 2'd1;
    localparam fwd_sel_t FWD_MEM_ALU  = 2'd2;
    localparam fwd_sel_t FWD_MEM_LOAD = 2'd3;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } hz_state_e;

    // Destination/control view of one downstream pipeline stage.
    typedef struct packed {
        logic      wreg;
        logic      m2reg;
        reg_addr_t dest;
    } stage_ctl_t;

    // A stage supplies a source operand only if it writes a non-zero register matching it.
    function automatic logic dest_hit(input stage_ctl_t ctl, input reg_addr_t src, input logic uses);
        return uses & ctl.wreg & (ctl.dest != '0) & (ctl.dest == src);
    endfunction

endpackage

// File: rtl/id_hazard_forward_unit_fwd_select.sv
// Per-operand forward select and load-use detection; purely combinational.
module id_hazard_forward_unit_fwd_select
    import id_hazard_forward_unit_pkg::*;
(
    input  reg_addr_t  i_src,
    input  logic       i_uses,
    input  stage_ctl_t i_exe,
    input  stage_ctl_t i_mem,
    output fwd_sel_t   o_sel_c,
    output logic       o_load_use_c
);

    logic w_exe_hit;
    logic w_mem_hit;

    assign w_exe_hit = dest_hit(i_exe, i_src, i_uses);
    assign w_mem_hit = dest_hit(i_mem, i_src, i_uses);

    // A load still in EXE has no data yet: select the regfile and let the stall cover it.
    assign o_load_use_c = w_exe_hit & i_exe.m2reg;

    always_comb begin
        o_sel_c = FWD_REG;
        if (w_exe_hit) begin
            o_sel_c = i_exe.m2reg ? FWD_REG : FWD_EXE_ALU;
        end else if (w_mem_hit) begin
            o_sel_c = i_mem.m2reg ? FWD_MEM_LOAD : FWD_MEM_ALU;
        end
    end

endmodule

// File: rtl/id_hazard_forward_unit.sv
// ID-stage hazard unit: shadows EXE->MEM control, selects operand forwarding
// and inserts a single bubble on each load-use dependency.
module id_hazard_forward_unit
    import id_hazard_forward_unit_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [REG_ADDR_W-1:0]  rs,
    input  logic [REG_ADDR_W-1:0]  rt,
    input  logic                   usesRs,
    input  logic                   usesRt,
    input  logic                   ewreg,
    input  logic                   em2reg,
    input  logic [REG_ADDR_W-1:0]  edestReg,
    output logic [FWD_SEL_W-1:0]   fwda,
    output logic [FWD_SEL_W-1:0]   fwdb,
    output logic                   wpcir,
    output logic                   bubble,
    output logic                   mwreg,
    output logic                   mm2reg,
    output logic [REG_ADDR_W-1:0]  mdestReg,
    output logic [STALL_CNT_W-1:0] stallCount
);

    stage_ctl_t            w_exe;
    stage_ctl_t            r_mem;
    hz_state_e             r_state;
    hz_state_e             w_next_state;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    fwd_sel_t              w_sel_a;
    fwd_sel_t              w_sel_b;
    logic                  w_lu_a;
    logic                  w_lu_b;
    logic                  w_load_use;
    logic                  w_wpcir;
    logic                  w_bubble;

    assign w_exe = '{wreg: ewreg, m2reg: em2reg, dest: edestReg};

    id_hazard_forward_unit_fwd_select u_fwd_a (
        .i_src        (rs),
        .i_uses       (usesRs),
        .i_exe        (w_exe),
        .i_mem        (r_mem),
        .o_sel_c      (w_sel_a),
        .o_load_use_c (w_lu_a)
    );

    id_hazard_forward_unit_fwd_select u_fwd_b (
        .i_src        (rt),
        .i_uses       (usesRt),
        .i_exe        (w_exe),
        .i_mem        (r_mem),
        .o_sel_c      (w_sel_b),
        .o_load_use_c (w_lu_b)
    );

    assign w_load_use = w_lu_a | w_lu_b;

    // EXE control becomes the MEM shadow one cycle later.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_mem <= '0;
        end else begin
            r_mem <= w_exe;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:      if (w_load_use) w_next_state = ST_LU_STALL;
            ST_LU_STALL: w_next_state = ST_RUN;
            default:     w_next_state = ST_RUN;
        endcase
    end

    // In LU_STALL the bubble already sits in EXE, so the pipeline is always released.
    always_comb begin
        w_wpcir  = 1'b1;
        w_bubble = 1'b0;
        if (resetn && (r_state == ST_RUN) && w_load_use) begin
            w_wpcir  = 1'b0;
            w_bubble = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (w_bubble && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign fwda       = resetn ? w_sel_a : FWD_REG;
    assign fwdb       = resetn ? w_sel_b : FWD_REG;
    assign wpcir      = w_wpcir;
    assign bubble     = w_bubble;
    assign mwreg      = r_mem.wreg;
    assign mm2reg     = r_mem.m2reg;
    assign mdestReg   = r_mem.dest;
    assign stallCount = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_forward_unit.sv
// Scoreboard bench for id_hazard_forward_unit: a behavioural model predicts each
// cycle's outputs, which are queued at drive time and compared mid-cycle.
module tb_id_hazard_forward_unit;

    logic        clock = 1'b0;
    logic        resetn;
    logic [4:0]  rs, rt, edestReg;
    logic        usesRs, usesRt, ewreg, em2reg;
    logic [1:0]  fwda, fwdb;
    logic        wpcir, bubble, mwreg, mm2reg;
    logic [4:0]  mdestReg;
    logic [15:0] stallCount;
    logic [1:0]  fwda_s, fwdb_s;
    logic        wpcir_s, bubble_s, mwreg_s, mm2reg_s;
    logic [4:0]  mdestReg_s;
    logic [1:0]  stallCount_s;

    id_hazard_forward_unit #(.STALL_CNT_W(16)) dut (
        .clock(clock), .resetn(resetn), .rs(rs), .rt(rt),
        .usesRs(usesRs), .usesRt(usesRt), .ewreg(ewreg), .em2reg(em2reg),
        .edestReg(edestReg), .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir),
        .bubble(bubble), .mwreg(mwreg), .mm2reg(mm2reg), .mdestReg(mdestReg),
        .stallCount(stallCount)
    );

    id_hazard_forward_unit #(.STALL_CNT_W(2)) dut_sat (
        .clock(clock), .resetn(resetn), .rs(rs), .rt(rt),
        .usesRs(usesRs), .usesRt(usesRt), .ewreg(ewreg), .em2reg(em2reg),
        .edestReg(edestReg), .fwda(fwda_s), .fwdb(fwdb_s), .wpcir(wpcir_s),
        .bubble(bubble_s), .mwreg(mwreg_s), .mm2reg(mm2reg_s), .mdestReg(mdestReg_s),
        .stallCount(stallCount_s)
    );

    always #5 clock = ~clock;

    typedef struct {
        int fwda, fwdb, wpcir, bubble, mwreg, mm2reg, mdest, cnt, sat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    // Model state: MEM shadow, stall state and both counters.
    int   m_mw = 0, m_mm2 = 0, m_md = 0, m_stall = 0, m_cnt = 0, m_sat = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d expected %0d", tag, step_no, got, exp);
        end
    endtask

    function automatic int pick(input bit exe, input bit mem, input int em, input int mm2);
        if (exe) return em ? 0 : 1;
        if (mem) return mm2 ? 3 : 2;
        return 0;
    endfunction

    task automatic step(input bit rn, input int a, input int b, input bit ua, input bit ub,
                        input bit ew, input bit em, input int ed);
        exp_t e, g;
        bit exa, exb, mea, meb, lu;
        resetn = rn; rs = 5'(a); rt = 5'(b); usesRs = ua; usesRt = ub;
        ewreg = ew; em2reg = em; edestReg = 5'(ed);
        exa = ua && ew && ed != 0 && ed == a;
        exb = ub && ew && ed != 0 && ed == b;
        mea = ua && m_mw != 0 && m_md != 0 && m_md == a;
        meb = ub && m_mw != 0 && m_md != 0 && m_md == b;
        lu  = em && (exa || exb);
        e.fwda   = rn ? pick(exa, mea, int'(em), m_mm2) : 0;
        e.fwdb   = rn ? pick(exb, meb, int'(em), m_mm2) : 0;
        e.bubble = (rn && m_stall == 0 && lu) ? 1 : 0;
        e.wpcir  = 1 - e.bubble;
        e.mwreg  = m_mw; e.mm2reg = m_mm2; e.mdest = m_md;
        e.cnt    = m_cnt; e.sat = m_sat;
        sb.push_back(e);

        @(negedge clock);
        g = sb.pop_front();
        chk("fwda", int'(fwda), g.fwda);
        chk("fwdb", int'(fwdb), g.fwdb);
        chk("wpcir", int'(wpcir), g.wpcir);
        chk("bubble", int'(bubble), g.bubble);
        chk("mwreg", int'(mwreg), g.mwreg);
        chk("mm2reg", int'(mm2reg), g.mm2reg);
        chk("mdestReg", int'(mdestReg), g.mdest);
        chk("stallCount", int'(stallCount), g.cnt);
        chk("stallCount_sat", int'(stallCount_s), g.sat);

        if (!rn) begin
            m_mw = 0; m_mm2 = 0; m_md = 0; m_stall = 0; m_cnt = 0; m_sat = 0;
        end else begin
            m_mw = ew; m_mm2 = em; m_md = ed; m_stall = e.bubble;
            if (e.bubble != 0) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_sat < 3) m_sat++;
            end
        end
        step_no++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn = 1'b0; rs = 5'd5; rt = 5'd0; usesRs = 1'b1; usesRt = 1'b0;
        ewreg = 1'b1; em2reg = 1'b0; edestReg = 5'd5;
        @(posedge clock);
        #1;

        // reset held with an active EXE writer
        step(0, 5, 0, 1, 0, 1, 0, 5);
        // EXE ALU forward, then the same value from MEM
        step(1, 8, 0, 1, 0, 1, 0, 8);
        step(1, 8, 0, 1, 0, 0, 0, 0);
        // load-use on rt, then load data from MEM
        step(1, 0, 9, 0, 1, 1, 1, 9);
        step(1, 0, 9, 0, 1, 0, 0, 0);
        // EXE beats MEM, $0 never forwarded, unused operand ignored
        step(1, 4, 0, 1, 0, 1, 0, 4);
        step(1, 4, 0, 1, 0, 1, 0, 4);
        step(1, 0, 0, 1, 0, 1, 0, 0);
        step(1, 3, 0, 0, 0, 1, 0, 3);
        step(1, 3, 0, 0, 0, 0, 0, 0);
        // rs == rt, both used
        step(1, 6, 6, 1, 1, 1, 0, 6);
        step(1, 6, 6, 1, 1, 0, 0, 0);
        // back-to-back dependent loads
        step(1, 10, 0, 1, 0, 1, 1, 10);
        step(1, 10, 0, 1, 0, 0, 0, 0);
        step(1, 11, 0, 1, 0, 1, 1, 11);
        step(1, 11, 0, 1, 0, 0, 0, 0);
        // load-use still visible during LU_STALL must not bubble twice
        step(1, 12, 0, 1, 0, 1, 1, 12);
        step(1, 12, 0, 1, 0, 1, 1, 12);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // saturation: 5 stalls after a fresh reset
        step(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 13, 0, 1, 1, 1, 13);
            step(1, 0, 13, 0, 1, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // reset during LU_STALL, then a new load-use must stall again
        step(1, 14, 0, 1, 0, 1, 1, 14);
        step(0, 14, 0, 1, 0, 0, 0, 0);
        step(1, 14, 0, 1, 0, 1, 1, 14);
        step(1, 14, 0, 1, 0, 0, 0, 0);

        // random traffic over a small register range
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 15) != 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
